// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I control sequencer over one shared instruction/data memory port.
// Optional illegal-opcode trap is enabled by defining SEQ_TRAP_ILLEGAL_EN.
module multicycle_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        dec_reg_we,
  input  logic        dec_mem_we,
  input  logic        dec_pc_sel,
  input  logic [1:0]  dec_wb_sel,
  input  logic        mem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        mem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic        bus_err,
  output logic        trap,
  output logic [31:0] instret
);

  // state  | meaning
  // FETCH  | instruction read on the shared port
  // DECODE | one cycle for the decoder to settle on the new IR
  // EXEC   | pick memory or writeback path from the opcode
  // MEM    | load/store on the shared port
  // WB     | register write, PC update, retire
  // ERR    | memory timeout, parked until reset
  // TRAP   | illegal opcode, parked until reset
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    ERR    = 3'd5,
    TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  state_t           state_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             timed_out;
  logic             is_mem_op;

  assign state     = state_q;
  assign is_mem_op = (opcode == OP_LOAD) || (opcode == OP_STORE);
  assign timed_out = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT)) && !mem_ready;

`ifdef SEQ_TRAP_ILLEGAL_EN
  logic is_legal;
  always_comb begin
    case (opcode)
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
      7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011: is_legal = 1'b1;
      default:                                        is_legal = 1'b0;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH;
      wait_cnt <= '0;
      instret  <= '0;
      bus_err  <= 1'b0;
      trap     <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (mem_ready) begin
            state_q <= DECODE;
          end else if (timed_out) begin
            state_q <= ERR;
            bus_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        DECODE: state_q <= EXEC;
        EXEC: begin
`ifdef SEQ_TRAP_ILLEGAL_EN
          if (!is_legal) begin
            state_q <= TRAP;
            trap    <= 1'b1;
          end else
`endif
          if (is_mem_op) begin
            state_q  <= MEM;
            wait_cnt <= '0;
          end else begin
            state_q <= WB;
          end
        end
        MEM: begin
          if (mem_ready) begin
            if (opcode == OP_STORE) begin
              state_q  <= FETCH;
              wait_cnt <= '0;
              instret  <= instret + 32'd1;
            end else begin
              state_q <= WB;
            end
          end else if (timed_out) begin
            state_q <= ERR;
            bus_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        WB: begin
          state_q  <= FETCH;
          wait_cnt <= '0;
          instret  <= instret + 32'd1;
        end
        ERR:     state_q <= ERR;
        TRAP:    state_q <= TRAP;
        default: state_q <= ERR;
      endcase
    end
  end

  // Strobes decode the current state; reset masks them so an abandoned instruction writes nothing.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    mem_we   = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 1'b0;
    reg_we   = 1'b0;
    wb_sel   = 2'b00;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          imem_req = 1'b1;
          ir_we    = mem_ready;
        end
        MEM: begin
          dmem_req = 1'b1;
          mem_we   = dec_mem_we;
          if (mem_ready && (opcode == OP_STORE)) begin
            pc_we  = 1'b1;
            pc_sel = dec_pc_sel;
          end
        end
        WB: begin
          reg_we = dec_reg_we;
          wb_sel = dec_wb_sel;
          pc_we  = 1'b1;
          pc_sel = dec_pc_sel;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer (default TIMEOUT=16).
// Expectations for the illegal-opcode case follow SEQ_TRAP_ILLEGAL_EN.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic        dec_reg_we, dec_mem_we, dec_pc_sel;
  logic [1:0]  dec_wb_sel;
  logic        mem_ready;
  logic        imem_req, dmem_req, mem_we, ir_we, pc_we, pc_sel, reg_we;
  logic [1:0]  wb_sel;
  logic [2:0]  state;
  logic        bus_err, trap;
  logic [31:0] instret;

  int checks   = 0;
  int failures = 0;

  localparam logic [6:0] OP_ADD   = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  multicycle_sequencer dut (
    .clk(clk), .rst(rst), .opcode(opcode), .dec_reg_we(dec_reg_we),
    .dec_mem_we(dec_mem_we), .dec_pc_sel(dec_pc_sel), .dec_wb_sel(dec_wb_sel),
    .mem_ready(mem_ready), .imem_req(imem_req), .dmem_req(dmem_req),
    .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .reg_we(reg_we), .wb_sel(wb_sel), .state(state), .bus_err(bus_err),
    .trap(trap), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] strobes();
    return {imem_req, dmem_req, mem_we, ir_we, pc_we, pc_sel, reg_we, |wb_sel};
  endfunction

  // Runs one instruction from FETCH; mem_ready is held low for fw fetch cycles
  // and mw mem cycles, and high everywhere else (where it must be ignored).
  task automatic run_instr(input logic [6:0] op, input logic rw, input logic mw_en,
                           input logic ps, input logic [1:0] wb, input int fw,
                           input int mw, input int max_cyc,
                           output int cycles, output int reg_cyc, output int pc_cyc,
                           output int n_reg, output int n_memwe, output logic [1:0] wb_seen,
                           output logic ps_seen);
    int cf = 0, cm = 0;
    logic done = 1'b0;
    opcode = op; dec_reg_we = rw; dec_mem_we = mw_en; dec_pc_sel = ps; dec_wb_sel = wb;
    cycles = -1; reg_cyc = -1; pc_cyc = -1; n_reg = 0; n_memwe = 0;
    wb_seen = 2'b00; ps_seen = 1'b0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      if (state == 3'd0)      mem_ready = (cf >= fw);
      else if (state == 3'd3) mem_ready = (cm >= mw);
      else                    mem_ready = 1'b1;
      #1;
      if (reg_we) begin n_reg++; reg_cyc = c; wb_seen = wb_sel; end
      if (mem_we) n_memwe++;
      if (pc_we) begin pc_cyc = c; ps_seen = pc_sel; done = 1'b1; cycles = c + 1; end
      if (state == 3'd0) cf++;
      if (state == 3'd3) cm++;
      tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  int cyc, rc, pcc, nr, nm;
  logic [1:0] wbs;
  logic pss;

  initial begin
    rst = 1'b1; opcode = OP_ADD; dec_reg_we = 1'b1; dec_mem_we = 1'b1;
    dec_pc_sel = 1'b1; dec_wb_sel = 2'd1; mem_ready = 1'b1;

    // Reset: strobes masked while rst is high
    tick();
    chk("rst_strobes_c0", {24'd0, strobes()}, 32'd0);
    tick();
    chk("rst_strobes_c1", {24'd0, strobes()}, 32'd0);
    chk("rst_state", {29'd0, state}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_imem_req", {31'd0, imem_req}, 32'd1);
    chk("post_rst_ir_we", {31'd0, ir_we}, 32'd1);
    chk("post_rst_instret", instret, 32'd0);
    chk("post_rst_flags", {30'd0, bus_err, trap}, 32'd0);

    // ADD, zero-wait
    run_instr(OP_ADD, 1'b1, 1'b0, 1'b0, 2'd1, 0, 0, 20, cyc, rc, pcc, nr, nm, wbs, pss);
    chk("add_cycles", cyc, 32'd4);
    chk("add_reg_cyc", rc, 32'd3);
    chk("add_pc_cyc", pcc, 32'd3);
    chk("add_n_reg", nr, 32'd1);
    chk("add_wb_sel", {30'd0, wbs}, 32'd1);
    chk("add_instret", instret, 32'd1);

    // Load with 3 wait cycles in MEM
    run_instr(OP_LOAD, 1'b1, 1'b0, 1'b0, 2'd3, 0, 3, 20, cyc, rc, pcc, nr, nm, wbs, pss);
    chk("load_cycles", cyc, 32'd8);
    chk("load_reg_cyc", rc, 32'd7);
    chk("load_wb_sel", {30'd0, wbs}, 32'd3);
    chk("load_memwe", nm, 32'd0);
    chk("load_instret", instret, 32'd2);

    // Store: mem_we only in MEM, never reg_we
    run_instr(OP_STORE, 1'b1, 1'b1, 1'b1, 2'd2, 0, 0, 20, cyc, rc, pcc, nr, nm, wbs, pss);
    chk("store_cycles", cyc, 32'd4);
    chk("store_memwe", nm, 32'd1);
    chk("store_n_reg", nr, 32'd0);
    chk("store_pc_sel", {31'd0, pss}, 32'd1);
    chk("store_instret", instret, 32'd3);

    // Fetch wait of exactly TIMEOUT cycles: ready on the last cycle wins
    run_instr(OP_ADD, 1'b1, 1'b0, 1'b1, 2'd0, 16, 0, 40, cyc, rc, pcc, nr, nm, wbs, pss);
    chk("fw16_cycles", cyc, 32'd20);
    chk("fw16_pc_sel", {31'd0, pss}, 32'd1);
    chk("fw16_no_err", {31'd0, bus_err}, 32'd0);
    chk("fw16_instret", instret, 32'd4);

    // instret wrap
    mem_ready = 1'b0;
    force dut.instret = 32'hFFFF_FFFF;
    tick();
    release dut.instret;
    #1;
    run_instr(OP_ADD, 1'b1, 1'b0, 1'b0, 2'd1, 0, 0, 20, cyc, rc, pcc, nr, nm, wbs, pss);
    chk("wrap_instret", instret, 32'd0);

    // Reset during WB abandons the instruction
    opcode = OP_ADD; dec_reg_we = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 10 && state != 3'd4; i++) tick();
    chk("rstwb_in_wb", {29'd0, state}, 32'd4);
    rst = 1'b1;
    #1;
    chk("rstwb_reg_we", {31'd0, reg_we}, 32'd0);
    chk("rstwb_pc_we", {31'd0, pc_we}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rstwb_instret", instret, 32'd0);
    chk("rstwb_state", {29'd0, state}, 32'd0);

    // Illegal opcode
`ifdef SEQ_TRAP_ILLEGAL_EN
    run_instr(OP_SYS, 1'b1, 1'b0, 1'b0, 2'd1, 0, 0, 12, cyc, rc, pcc, nr, nm, wbs, pss);
    chk("trap_no_pc_we", pcc, 32'hFFFF_FFFF);
    chk("trap_state", {29'd0, state}, 32'd6);
    chk("trap_flag", {31'd0, trap}, 32'd1);
    chk("trap_strobes", {24'd0, strobes()}, 32'd0);
    chk("trap_instret", instret, 32'd0);
`else
    run_instr(OP_SYS, 1'b1, 1'b0, 1'b0, 2'd1, 0, 0, 12, cyc, rc, pcc, nr, nm, wbs, pss);
    chk("illegal_cycles", cyc, 32'd4);
    chk("illegal_n_reg", nr, 32'd1);
    chk("illegal_trap", {31'd0, trap}, 32'd0);
    chk("illegal_instret", instret, 32'd1);
`endif

    // Timeout in FETCH
    do_reset();
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) tick();
    chk("to_c16_state", {29'd0, state}, 32'd0);
    chk("to_c16_bus_err", {31'd0, bus_err}, 32'd0);
    tick();
    chk("to_err_state", {29'd0, state}, 32'd5);
    chk("to_bus_err", {31'd0, bus_err}, 32'd1);
    chk("to_err_strobes", {24'd0, strobes()}, 32'd0);
    mem_ready = 1'b1;
    tick(); tick(); tick();
    chk("to_err_sticky_state", {29'd0, state}, 32'd5);
    chk("to_err_sticky_flag", {31'd0, bus_err}, 32'd1);
    chk("to_err_sticky_strobes", {24'd0, strobes()}, 32'd0);
    do_reset();
    #1;
    chk("to_cleared", {31'd0, bus_err}, 32'd0);
    chk("to_after_rst_state", {29'd0, state}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
